// File: rtl/pipe_temp.sv
// -----------------------------------------------------------------------------
// pipe_temp
//   Pipeline temperature supervisor. Each clock the 8-bit ADC temperature code
//   is classified into NORMAL, ALARM or SHUTDOWN and the zone is registered.
//   The flags driven to the plant-protection logic are decoded straight from
//   the state flops. They are not latched: each registered zone depends only
//   on the most recent sample.
//
// Parameters
//   ALARM_TH  lowest code (inclusive) classified as alarm
//   SHUT_TH   lowest code (inclusive) classified as shutdown (ALARM_TH < SHUT_TH)
//
// Ports
//   clk       in   1  rising-edge clock
//   reset     in   1  asynchronous, active-low reset (forces NORMAL)
//   adc_out   in   8  unsigned temperature code
//   alarm     out  1  last sampled code was in the alarm zone
//   shutdown  out  1  last sampled code was in the shutdown zone
// -----------------------------------------------------------------------------
module pipe_temp #(
   parameter logic [7:0] ALARM_TH = 8'd180,
   parameter logic [7:0] SHUT_TH  = 8'd240
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] adc_out,
   output logic       alarm,
   output logic       shutdown
);

   // Each flag owns one bit of the encoding, so the outputs are the state
   // flops themselves and the two flags can never be high together.
   typedef enum logic [1:0] {
      NORMAL   = 2'b00,
      ALARM    = 2'b01,
      SHUTDOWN = 2'b10
   } state_t;

   state_t state_q;
   state_t state_d;

   // Shutdown is tested first so it takes priority over alarm.
   function automatic state_t zone_of(input logic [7:0] code);
      if (code >= SHUT_TH) begin
         return SHUTDOWN;
      end else if (code >= ALARM_TH) begin
         return ALARM;
      end else begin
         return NORMAL;
      end
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= NORMAL;
      end else begin
         state_q <= state_d;
      end
   end

   // No hysteresis: the next zone is purely the zone of the current sample.
   always_comb begin
      state_d = NORMAL;
      state_d = zone_of(adc_out);
   end

   assign alarm    = state_q[0];
   assign shutdown = state_q[1];

endmodule

// File: tb/tb_pipe_temp.sv
module tb_pipe_temp;

   localparam logic [7:0] A_TH = 8'd180;
   localparam logic [7:0] S_TH = 8'd240;

   logic       clk;
   logic       reset;
   logic [7:0] adc_out;
   logic       alarm;
   logic       shutdown;

   int checks;
   int failures;

   logic [1:0] exp_q[$];

   pipe_temp #(
      .ALARM_TH(A_TH),
      .SHUT_TH (S_TH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .adc_out (adc_out),
      .alarm   (alarm),
      .shutdown(shutdown)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference classification, returned as {alarm, shutdown}.
   function automatic logic [1:0] model(input logic [7:0] v);
      if (v >= S_TH)      return 2'b01;
      else if (v >= A_TH) return 2'b10;
      else                return 2'b00;
   endfunction

   task automatic check_val(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got {alarm,shutdown}=%b expected %b", tag, obs, exp);
      end
   endtask

   // Present one sample, push its expectation, then after the sampling edge
   // pop and compare against the registered outputs.
   task automatic drive(input string tag, input logic [7:0] v);
      logic [1:0] e;
      adc_out = v;
      exp_q.push_back(model(v));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         check_val(tag, {alarm, shutdown}, e);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      adc_out  = 8'd255;

      // Reset held low with a shutdown-level input: outputs stay 0.
      #1;
      check_val("reset_imm", {alarm, shutdown}, 2'b00);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_val("reset_hold", {alarm, shutdown}, 2'b00);
      end

      // Release away from the active edge, then the first classification.
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      drive("release_100", 8'd100);
      check_val("release_100_lit", {alarm, shutdown}, 2'b00);

      // Successive classifications, with literal expectations alongside.
      drive("seq_100", 8'd100);
      drive("seq_200", 8'd200);
      check_val("seq_200_lit", {alarm, shutdown}, 2'b10);
      drive("seq_0", 8'd0);
      drive("seq_255", 8'd255);
      check_val("seq_255_lit", {alarm, shutdown}, 2'b01);

      // No latching.
      drive("nolatch_200", 8'd200);
      drive("nolatch_0", 8'd0);
      drive("a2s_200", 8'd200);
      drive("a2s_255", 8'd255);

      // Direct exits from SHUTDOWN.
      drive("s2n_255", 8'd255);
      drive("s2n_0", 8'd0);
      drive("s2a_255", 8'd255);
      drive("s2a_200", 8'd200);
      drive("s2s_255a", 8'd255);
      drive("s2s_255b", 8'd255);

      // Boundary sweep.
      drive("bnd_179", 8'd179);
      check_val("bnd_179_lit", {alarm, shutdown}, 2'b00);
      drive("bnd_180", 8'd180);
      check_val("bnd_180_lit", {alarm, shutdown}, 2'b10);
      drive("bnd_239", 8'd239);
      check_val("bnd_239_lit", {alarm, shutdown}, 2'b10);
      drive("bnd_240", 8'd240);
      check_val("bnd_240_lit", {alarm, shutdown}, 2'b01);
      drive("bnd_0", 8'd0);

      // A few random samples through the scoreboard.
      for (int i = 0; i < 8; i++) begin
         drive("rand", 8'($urandom_range(0, 255)));
      end

      // Mid-cycle reset while shutdown is high.
      drive("mid_255", 8'd255);
      #2;
      reset = 1'b0;
      #1;
      check_val("mid_reset_async", {alarm, shutdown}, 2'b00);
      adc_out = 8'd0;
      @(negedge clk);
      check_val("mid_reset_held", {alarm, shutdown}, 2'b00);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_val("post_release_edge", {alarm, shutdown}, 2'b00);
      drive("post_release_0a", 8'd0);
      drive("post_release_0b", 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
